// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
//   sub_state_t : FSM encoding (IDLE, BUSY, DONE)
//   cnt_width() : bit counter width, never narrower than one bit
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake bundle for the bit-serial subtractor.
//   in_valid/in_ready   : operand handshake carrying a (minuend) and b (subtrahend)
//   out_valid/out_ready : result handshake carrying diff, borrow_out, overflow
// master = producer/consumer side (testbench or datapath), slave = subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow_out, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor_fullsubtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout set when a borrow is needed.
//   a, b : operand bits    bin : incoming borrow
//   d    : difference bit  bout: outgoing borrow
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of serial_subtractor_if (operand and result handshakes)
// One op takes WIDTH BUSY cycles; the result is held in DONE until out_ready.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH:0]   diff_ext;

  fullsubtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (brw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New difference bit enters at the MSB; after WIDTH shifts the LSB lands at bit 0.
  // Built one bit wider so the slice also works for WIDTH == 1.
  assign diff_ext = {fs_d, diff_q};

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    brw_d        = brw_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          // Operand sign bits are shifted out during BUSY, so keep them for the overflow flag.
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        brw_d  = fs_bout;
        diff_d = diff_ext[WIDTH:1];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // fs_d is the result's sign bit on the final step.
          borrow_out_d = fs_bout;
          overflow_d   = (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
          state_d      = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      brw_q        <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      brw_q        <= brw_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  // in_ready drops with rst immediately, not just at the next edge.
  assign bus.in_ready   = (state_q == IDLE) && !rst;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.overflow   = overflow_q;

endmodule
